// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two write lanes and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to read ports.
module regfile_mp_sb #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 8,
   parameter int ADDR_W    = $clog2(DEPTH),
   parameter int NUM_RD    = 3,
   parameter bit ZERO_REG0 = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [DEPTH*DATA_W-1:0]  init_flat,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [1:0]               wr_en,
   input  logic [2*ADDR_W-1:0]      wr_addr,
   input  logic [2*DATA_W-1:0]      wr_data,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic [ADDR_W:0]          busy_cnt,
   output logic                     wr_conflict
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_busy;
   logic [ADDR_W:0]   r_busy_cnt;
   logic              r_conflict;

   logic [ADDR_W-1:0] w_wa0;
   logic [ADDR_W-1:0] w_wa1;
   logic [DATA_W-1:0] w_wd0;
   logic [DATA_W-1:0] w_wd1;
   logic              w_we0;
   logic              w_we1;
   logic              w_rsv;
   logic              w_conflict;
   logic [DEPTH-1:0]  w_busy_nxt;
   logic [ADDR_W:0]   w_cnt_nxt;

   assign w_wa0 = wr_addr[0 +: ADDR_W];
   assign w_wa1 = wr_addr[ADDR_W +: ADDR_W];
   assign w_wd0 = wr_data[0 +: DATA_W];
   assign w_wd1 = wr_data[DATA_W +: DATA_W];

   // With a hardwired register 0, anything aimed at it is dropped here
   assign w_we0 = wr_en[0] && !(ZERO_REG0 && w_wa0 == '0);
   assign w_we1 = wr_en[1] && !(ZERO_REG0 && w_wa1 == '0);
   assign w_rsv = rsv_en && !(ZERO_REG0 && rsv_addr == '0);

   assign w_conflict = w_we0 && w_we1 && (w_wa0 == w_wa1);

   // Reservation applied last so it survives a same-edge clear
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_we0) w_busy_nxt[w_wa0] = 1'b0;
      if (w_we1) w_busy_nxt[w_wa1] = 1'b0;
      if (w_rsv) w_busy_nxt[rsv_addr] = 1'b1;
      w_cnt_nxt = '0;
      for (int i = 0; i < DEPTH; i++)
         w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
   end

   always_ff @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= (ZERO_REG0 && i == 0) ? '0 :
                        init_flat[i*DATA_W +: DATA_W];
         r_busy     <= '0;
         r_busy_cnt <= '0;
         r_conflict <= 1'b0;
      end else begin
         if (w_we0) r_mem[w_wa0] <= w_wd0;
         if (w_we1) r_mem[w_wa1] <= w_wd1;
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= w_cnt_nxt;
         r_conflict <= w_conflict;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         rd_data[p*DATA_W +: DATA_W] = r_mem[rd_addr[p*ADDR_W +: ADDR_W]];
         rd_busy[p] = r_busy[rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
         if (w_we1 && rd_addr[p*ADDR_W +: ADDR_W] == w_wa1) begin
            rd_data[p*DATA_W +: DATA_W] = w_wd1;
            rd_busy[p] = w_rsv && (rsv_addr == w_wa1);
         end else if (w_we0 && rd_addr[p*ADDR_W +: ADDR_W] == w_wa0) begin
            rd_data[p*DATA_W +: DATA_W] = w_wd0;
            rd_busy[p] = w_rsv && (rsv_addr == w_wa0);
         end
`endif
      end
   end

   assign busy_cnt    = r_busy_cnt;
   assign wr_conflict = r_conflict;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: vector table plus bypass, reset and
// hardwired-zero sequences.
module tb_regfile_mp_sb;

   logic        clk;
   logic        rst_n;
   logic [255:0] init_flat;

   logic [8:0]  rd_addr;
   logic [95:0] rd_data;
   logic [2:0]  rd_busy;
   logic [1:0]  wr_en;
   logic [5:0]  wr_addr;
   logic [63:0] wr_data;
   logic        rsv_en;
   logic [2:0]  rsv_addr;
   logic [3:0]  busy_cnt;
   logic        wr_conflict;

   logic [8:0]  z_rd_addr;
   logic [95:0] z_rd_data;
   logic [2:0]  z_rd_busy;
   logic [1:0]  z_wr_en;
   logic [5:0]  z_wr_addr;
   logic [63:0] z_wr_data;
   logic        z_rsv_en;
   logic [2:0]  z_rsv_addr;
   logic [3:0]  z_busy_cnt;
   logic        z_wr_conflict;

   int n_chk;
   int n_fail;

   regfile_mp_sb u_dut (
      .clk        (clk),
      .reset_n    (rst_n),
      .init_flat  (init_flat),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_busy    (rd_busy),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rsv_en     (rsv_en),
      .rsv_addr   (rsv_addr),
      .busy_cnt   (busy_cnt),
      .wr_conflict(wr_conflict)
   );

   regfile_mp_sb #(.ZERO_REG0(1'b1)) u_z (
      .clk        (clk),
      .reset_n    (rst_n),
      .init_flat  (init_flat),
      .rd_addr    (z_rd_addr),
      .rd_data    (z_rd_data),
      .rd_busy    (z_rd_busy),
      .wr_en      (z_wr_en),
      .wr_addr    (z_wr_addr),
      .wr_data    (z_wr_data),
      .rsv_en     (z_rsv_en),
      .rsv_addr   (z_rsv_addr),
      .busy_cnt   (z_busy_cnt),
      .wr_conflict(z_wr_conflict)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  we;
      logic [2:0]  wa0;
      logic [2:0]  wa1;
      logic [31:0] wd0;
      logic [31:0] wd1;
      logic        rsv;
      logic [2:0]  rsva;
      logic [2:0]  r0;
      logic [2:0]  r1;
      logic [2:0]  r2;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [31:0] e2;
      logic [2:0]  eb;
      logic [3:0]  ec;
      logic        ef;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      rsv_en   = 1'b0;
      rsv_addr = '0;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      for (int i = 0; i < 8; i++)
         init_flat[i*32 +: 32] = 32'h1000 + i;
      rst_n = 1'b0;
      idle();
      rd_addr    = '0;
      z_rd_addr  = '0;
      z_wr_en    = '0;
      z_wr_addr  = '0;
      z_wr_data  = '0;
      z_rsv_en   = 1'b0;
      z_rsv_addr = '0;

      vecs[0]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 7,
                   32'h1000, 32'h1001, 32'h1007, 3'b000, 0, 0};
      vecs[1]  = '{2'b11, 3, 5, 32'hAAAA, 32'h5555, 0, 0, 3, 5, 4,
                   32'hAAAA, 32'h5555, 32'h1004, 3'b000, 0, 0};
      vecs[2]  = '{2'b11, 2, 2, 32'h1, 32'h2, 0, 0, 2, 3, 5,
                   32'h2, 32'hAAAA, 32'h5555, 3'b000, 0, 1};
      vecs[3]  = '{2'b00, 0, 0, 0, 0, 0, 0, 2, 0, 1,
                   32'h2, 32'h1000, 32'h1001, 3'b000, 0, 0};
      vecs[4]  = '{2'b00, 0, 0, 0, 0, 1, 4, 4, 6, 3,
                   32'h1004, 32'h1006, 32'hAAAA, 3'b001, 1, 0};
      vecs[5]  = '{2'b00, 0, 0, 0, 0, 1, 6, 4, 6, 5,
                   32'h1004, 32'h1006, 32'h5555, 3'b011, 2, 0};
      vecs[6]  = '{2'b01, 4, 0, 32'h44, 0, 0, 0, 4, 6, 2,
                   32'h44, 32'h1006, 32'h2, 3'b010, 1, 0};
      vecs[7]  = '{2'b10, 0, 6, 0, 32'h66, 1, 6, 6, 4, 0,
                   32'h66, 32'h44, 32'h1000, 3'b001, 1, 0};
      vecs[8]  = '{2'b01, 1, 0, 32'h11, 0, 1, 3, 1, 3, 6,
                   32'h11, 32'hAAAA, 32'h66, 3'b110, 2, 0};
      vecs[9]  = '{2'b11, 6, 3, 32'h60, 32'h33, 0, 0, 3, 6, 7,
                   32'h33, 32'h60, 32'h1007, 3'b000, 0, 0};
      vecs[10] = '{2'b00, 0, 0, 0, 0, 1, 7, 7, 7, 7,
                   32'h1007, 32'h1007, 32'h1007, 3'b111, 1, 0};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset contents
      for (int i = 0; i < 8; i++) begin
         rd_addr = {3'(i), 3'(7 - i), 3'(i)};
         #1;
         chk($sformatf("reset_rd%0d", i), rd_data[31:0], 32'h1000 + i);
         chk($sformatf("reset_rd%0d", 7 - i), rd_data[63:32],
             32'h1000 + (7 - i));
         chk($sformatf("reset_busy%0d", i), {29'd0, rd_busy}, 32'd0);
      end
      chk("reset_cnt", {28'd0, busy_cnt}, 32'd0);
      chk("reset_conflict", {31'd0, wr_conflict}, 32'd0);
      chk("z_reset_r0", z_rd_data[31:0], 32'd0);

      @(posedge clk);
      #1;
      for (int i = 0; i < 11; i++) begin
         wr_en    = vecs[i].we;
         wr_addr  = {vecs[i].wa1, vecs[i].wa0};
         wr_data  = {vecs[i].wd1, vecs[i].wd0};
         rsv_en   = vecs[i].rsv;
         rsv_addr = vecs[i].rsva;
         rd_addr  = {vecs[i].r2, vecs[i].r1, vecs[i].r0};
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_rd0", i), rd_data[31:0], vecs[i].e0);
         chk($sformatf("v%0d_rd1", i), rd_data[63:32], vecs[i].e1);
         chk($sformatf("v%0d_rd2", i), rd_data[95:64], vecs[i].e2);
         chk($sformatf("v%0d_busy", i), {29'd0, rd_busy},
             {29'd0, vecs[i].eb});
         chk($sformatf("v%0d_cnt", i), {28'd0, busy_cnt},
             {28'd0, vecs[i].ec});
         chk($sformatf("v%0d_conflict", i), {31'd0, wr_conflict},
             {31'd0, vecs[i].ef});
      end
      idle();

      // forwarding window before the falling edge; register 7 is reserved
      @(posedge clk);
      #1;
      rd_addr = {3'd0, 3'd0, 3'd7};
      wr_en   = 2'b01;
      wr_addr = {3'd0, 3'd7};
      wr_data = {32'd0, 32'hDEAD};
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("byp_pre_data", rd_data[31:0], 32'hDEAD);
      chk("byp_pre_busy", {31'd0, rd_busy[0]}, 32'd0);
`else
      chk("byp_pre_data", rd_data[31:0], 32'h1007);
      chk("byp_pre_busy", {31'd0, rd_busy[0]}, 32'd1);
`endif
      @(negedge clk);
      #1;
      chk("byp_post_data", rd_data[31:0], 32'hDEAD);
      chk("byp_post_busy", {31'd0, rd_busy[0]}, 32'd0);
      chk("byp_post_cnt", {28'd0, busy_cnt}, 32'd0);
      idle();

      // asynchronous reset mid-stream overrides a pending write
      rd_addr  = {3'd7, 3'd5, 3'd3};
      wr_en    = 2'b01;
      wr_addr  = {3'd0, 3'd3};
      wr_data  = {32'd0, 32'hBEEF};
      rsv_en   = 1'b1;
      rsv_addr = 3'd5;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_r3", rd_data[31:0], 32'h1003);
      chk("arst_r7", rd_data[95:64], 32'h1007);
      chk("arst_cnt", {28'd0, busy_cnt}, 32'd0);
      @(negedge clk);
      #1;
      chk("arst_hold_r3", rd_data[31:0], 32'h1003);
      chk("arst_hold_busy", {29'd0, rd_busy}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst_r3", rd_data[31:0], 32'hBEEF);
      chk("post_rst_busy5", {31'd0, rd_busy[1]}, 32'd1);
      chk("post_rst_cnt", {28'd0, busy_cnt}, 32'd1);
      idle();

      // hardwired register 0 instance
      z_rd_addr  = {3'd1, 3'd0, 3'd0};
      z_wr_en    = 2'b11;
      z_wr_addr  = {3'd0, 3'd0};
      z_wr_data  = {32'hFFFF, 32'hFFFF};
      z_rsv_en   = 1'b1;
      z_rsv_addr = 3'd0;
      @(negedge clk);
      #1;
      chk("z_r0_data", z_rd_data[31:0], 32'd0);
      chk("z_r0_busy", {31'd0, z_rd_busy[0]}, 32'd0);
      chk("z_r1_data", z_rd_data[95:64], 32'h1001);
      chk("z_cnt", {28'd0, z_busy_cnt}, 32'd0);
      chk("z_no_conflict", {31'd0, z_wr_conflict}, 32'd0);
      z_wr_addr  = {3'd1, 3'd1};
      z_wr_data  = {32'h88, 32'h77};
      z_rsv_addr = 3'd1;
      @(negedge clk);
      #1;
      chk("z_r1_lane1", z_rd_data[95:64], 32'h88);
      chk("z_r1_busy", {31'd0, z_rd_busy[2]}, 32'd1);
      chk("z_cnt1", {28'd0, z_busy_cnt}, 32'd1);
      chk("z_conflict", {31'd0, z_wr_conflict}, 32'd1);
      z_wr_en  = 2'b00;
      z_rsv_en = 1'b0;
      @(negedge clk);
      #1;
      chk("z_conflict_clr", {31'd0, z_wr_conflict}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_mp_sb.md
# regfile_mp_sb

Parametrised multi-port register file with a per-register busy scoreboard: DEPTH registers of DATA_W bits, NUM_RD combinational read ports, two write ports with fixed priority, and a reservation port that marks registers pending until written. It is the next-generation replacement for the fixed 8x32, 3-read/1-write register file in the datapath. It sits between decode (reads, reservations) and writeback (two commit lanes).

## Interface
- DATA_W, 32, register width
- DEPTH, 8, number of registers, power of two, >= 2
- ADDR_W, $clog2(DEPTH), address width (derived, do not override)
- NUM_RD, 3, number of read ports, 1..4
- ZERO_REG0, 0, 1 = register 0 reads 0, ignores writes and reservations, never busy

- clk  in  1  clock; all state updates on the falling edge
- reset_n  in  1  asynchronous, active-low reset
- init_flat  in  DEPTH*DATA_W  reset value; register i = init_flat[i*DATA_W +: DATA_W]
- rd_addr  in  NUM_RD*ADDR_W  read address, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port p at [p*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  busy bit of the register addressed by port p
- wr_en  in  2  write enable, lanes 0 and 1
- wr_addr  in  2*ADDR_W  write address per lane
- wr_data  in  2*DATA_W  write data per lane
- rsv_en  in  1  reserve request
- rsv_addr  in  ADDR_W  register to mark busy
- busy_cnt  out  ADDR_W+1  number of busy registers
- wr_conflict  out  1  registered flag: both lanes wrote the same address on the last edge

## Operation
- Storage: DEPTH x DATA_W flops plus DEPTH busy flops, all falling-edge clocked.
- Reset (reset_n low, asynchronous): register i <= init_flat slice i (with ZERO_REG0, register 0 <= 0); all busy bits <= 0; busy_cnt = 0; wr_conflict <= 0. init_flat is sampled continuously while reset_n is low.
- Reads: combinational; rd_data[p] = reg[rd_addr[p]] and rd_busy[p] = busy[rd_addr[p]]. Read ports are independent; any addresses may alias.
- Writes: on a falling edge, each lane with wr_en set writes wr_data to wr_addr.
- Same address on both lanes: lane 1 wins. wr_conflict <= 1 for the following cycle, otherwise 0.
- Scoreboard set: rsv_en on a falling edge sets busy[rsv_addr].
- Scoreboard clear: any enabled write clears busy[wr_addr], whether or not the register was busy.
- Reserve and write to the same address on the same edge: data is written and busy ends up 1, because the reservation is newer.
- busy_cnt: registered population count of busy, updated on the same edge as busy. Range 0..DEPTH; no wrap.
- ZERO_REG0=1: address 0 always reads data 0 and busy 0. Writes and reservations to address 0 are dropped, and address 0 never counts toward wr_conflict.

## Timing
- Read latency 0: combinational from rd_addr and current state.
- Write, reserve and clear take effect at the falling edge and are visible on rd_data, rd_busy and busy_cnt immediately after that edge.
- Rising-edge logic upstream therefore sees a write from the same cycle's falling edge at its next rising edge.
- wr_conflict is asserted for exactly one cycle, from the falling edge of the colliding write to the next falling edge.
- Reset asserted mid-operation overrides any write or reserve in progress. The first write is accepted at the first falling edge after reset_n rises.

## Configuration
- REGFILE_BYPASS_EN defined: a read whose address matches an enabled write lane returns that lane's wr_data combinationally; lane 1 wins if both lanes match. rd_busy for that port reads 0 unless rsv_en targets the same address in the same cycle.
- REGFILE_BYPASS_EN undefined: reads return stored state only; the new value appears after the falling edge.
- The macro does not change state-update behaviour, only read-path muxing.

## Test plan
- Reset: init_flat register i = 32'h1000+i, reset_n low then high -> all rd_data match the init values, rd_busy = 0, busy_cnt = 0, wr_conflict = 0.
- Dual write, distinct addresses: lane 0 writes 3<-32'hAAAA, lane 1 writes 5<-32'h5555 -> after the falling edge, reads of 3 and 5 return these values; wr_conflict = 0.
- Collision: both lanes write address 2, lane 0 32'h1, lane 1 32'h2 -> register 2 = 32'h2; wr_conflict = 1 for one cycle, then 0.
- Scoreboard: reserve 4 and 6 -> busy_cnt = 2, rd_busy high for both. Write 4 -> busy_cnt = 1. Reserve and write 6 on the same edge -> busy_cnt = 1 and register 6 still busy.
- Bypass: write 7<-32'hDEAD while reading 7. With REGFILE_BYPASS_EN, rd_data = 32'hDEAD before the edge; without it, the old value until the edge.
- ZERO_REG0=1: write 0<-32'hFFFF, reserve 0 -> rd_data = 0, rd_busy = 0, busy_cnt unchanged. Pulse reset_n low mid-stream -> state returns to the init values asynchronously.
